// File: rtl/uart_receiver_pkg.sv
// Shared types, constants and the NCO increment helper for the UART receive path.
package uart_receiver_pkg;

    localparam logic CLR = 1'b0;
    localparam logic SET = 1'b1;

    localparam int unsigned     ACC_W    = 17;
    localparam logic [ACC_W-1:0] ACC_INIT = 17'h10000;

    // Tick-counter positions inside one bit: three mid-bit samples and the bit end.
    localparam logic [3:0] TC_S0   = 4'd7;
    localparam logic [3:0] TC_S1   = 4'd8;
    localparam logic [3:0] TC_VOTE = 4'd9;
    localparam logic [3:0] TC_END  = 4'd15;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BRK   = 3'd4
    } rx_state_e;

    // Phase increment shared with the transmitter; 64-bit intermediate, truncated to the accumulator.
    function automatic logic [ACC_W-1:0] calc_nco_inc(input longint unsigned ovs,
                                                      input longint unsigned bdr,
                                                      input longint unsigned clk_div2);
        longint unsigned full;
        full = (ovs * bdr * 64'd65536) / clk_div2;
        return full[ACC_W-1:0];
    endfunction

endpackage

// File: rtl/uart_baud_nco.sv
// Oversample tick generator: phase accumulator whose bit 16 rising edge marks one tick.
module uart_baud_nco
    import uart_receiver_pkg::*;
#(
    parameter logic [ACC_W-1:0] NCO_INC = 17'd1207
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic             msb_q, msb_d;

    // Advance the phase; hold at the realign value while cleared so ticks restart from the start edge.
    always_comb begin
        acc_d = clr ? ACC_INIT : acc_q + NCO_INC;
        msb_d = acc_q[ACC_W-1];
    end

    // Accumulator and delayed MSB for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= ACC_INIT;
            msb_q <= SET;
        end else begin
            acc_q <= acc_d;
            msb_q <= msb_d;
        end
    end

    assign tick = acc_q[ACC_W-1] & ~msb_q;

endmodule

// File: rtl/uart_receiver.sv
// UART byte receiver: 2-FF synchronizer, 16x oversampling, 3-sample majority vote, stop-bit framing.
//
//  state    | meaning
//  ---------+-------------------------------------------------------------
//  ST_IDLE  | line idle, NCO held; waiting for a falling edge on rxs
//  ST_START | validating the start bit; high vote at mid-bit aborts
//  ST_DATA  | shifting in 8 data bits, LSB first
//  ST_STOP  | checking stop bit(s); good -> data_valid, low -> frame_err
//  ST_BRK   | framing error seen; wait for the line to go high again
module uart_receiver
    import uart_receiver_pkg::*;
#(
    parameter int unsigned DEFAULT_BDR  = 115200,
    parameter int unsigned SYS_CLK_DIV2 = 100_000_000,
    parameter int unsigned STOP_BIT     = 2,
    parameter int unsigned OVS          = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam logic [ACC_W-1:0] NCO_INC =
        calc_nco_inc(64'(OVS), 64'(DEFAULT_BDR), 64'(SYS_CLK_DIV2));
    localparam logic STOP_LAST = 1'(STOP_BIT - 1);

    rx_state_e  state_q, state_d;
    logic       sync1_q, sync1_d, rxs_q, rxs_d, rxs_prev_q, rxs_prev_d;
    logic [3:0] tcnt_q, tcnt_d;
    logic [1:0] smp_q, smp_d;
    logic       bit_q, bit_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic       stop_idx_q, stop_idx_d;
    logic [7:0] sh_q, sh_d;
    logic [7:0] data_q, data_d;
    logic       data_valid_q, data_valid_d;
    logic       frame_err_q, frame_err_d;

    logic tick, fall, vote, mid_tick, end_tick, nco_clr;

    assign nco_clr  = (state_q == ST_IDLE);
    assign fall     = rxs_prev_q & ~rxs_q;
    assign vote     = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxs_q) | (smp_q[1] & rxs_q);
    assign mid_tick = tick && (tcnt_q == TC_VOTE);
    assign end_tick = tick && (tcnt_q == TC_END);

    uart_baud_nco #(.NCO_INC(NCO_INC)) u_nco (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (nco_clr),
        .tick  (tick)
    );

    // Synchronizer chain, tick counter and mid-bit sample capture.
    always_comb begin
        sync1_d    = rxd;
        rxs_d      = sync1_q;
        rxs_prev_d = rxs_q;
        tcnt_d     = tcnt_q;
        smp_d      = smp_q;
        bit_d      = bit_q;
        if ((state_d != state_q) || (state_q == ST_IDLE)) begin
            tcnt_d = '0;
        end else if (tick) begin
            tcnt_d = tcnt_q + 4'd1;
        end
        if (tick && (tcnt_q == TC_S0)) smp_d[0] = rxs_q;
        if (tick && (tcnt_q == TC_S1)) smp_d[1] = rxs_q;
        if (mid_tick) bit_d = vote;
    end

    // Next-state and output decode; strobes default low so they last exactly one clk.
    always_comb begin
        state_d      = state_q;
        bit_idx_d    = bit_idx_q;
        stop_idx_d   = stop_idx_q;
        sh_d         = sh_q;
        data_d       = data_q;
        data_valid_d = CLR;
        frame_err_d  = CLR;
        case (state_q)
            ST_IDLE: begin
                if (fall) state_d = ST_START;
            end
            ST_START: begin
                if (mid_tick && vote) begin
                    state_d = ST_IDLE;
                end else if (end_tick) begin
                    state_d   = ST_DATA;
                    bit_idx_d = '0;
                end
            end
            ST_DATA: begin
                if (end_tick) begin
                    sh_d = {bit_q, sh_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d    = ST_STOP;
                        stop_idx_d = CLR;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                // Leaving at mid-bit of the last stop bit leaves half a bit of slack for the next start edge.
                if (mid_tick) begin
                    if (!vote) begin
                        data_d      = sh_q;
                        frame_err_d = SET;
                        state_d     = ST_BRK;
                    end else if (stop_idx_q == STOP_LAST) begin
                        data_d       = sh_q;
                        data_valid_d = SET;
                        state_d      = ST_IDLE;
                    end
                end else if (end_tick) begin
                    stop_idx_d = stop_idx_q + 1'b1;
                end
            end
            ST_BRK: begin
                if (rxs_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            sync1_q      <= SET;
            rxs_q        <= SET;
            rxs_prev_q   <= SET;
            tcnt_q       <= '0;
            smp_q        <= '0;
            bit_q        <= CLR;
            bit_idx_q    <= '0;
            stop_idx_q   <= CLR;
            sh_q         <= '0;
            data_q       <= '0;
            data_valid_q <= CLR;
            frame_err_q  <= CLR;
        end else begin
            state_q      <= state_d;
            sync1_q      <= sync1_d;
            rxs_q        <= rxs_d;
            rxs_prev_q   <= rxs_prev_d;
            tcnt_q       <= tcnt_d;
            smp_q        <= smp_d;
            bit_q        <= bit_d;
            bit_idx_q    <= bit_idx_d;
            stop_idx_q   <= stop_idx_d;
            sh_q         <= sh_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign data       = data_q;
    assign data_valid = data_valid_q;
    assign frame_err  = frame_err_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: serial frames driven at nominal and skewed rates, outcomes predicted
// from what was put on the line and compared every clk against the observed strobes and data.
module tb_uart_receiver;

    localparam int BIT_CLK = 64;   // 2*SYS_CLK_DIV2/DEFAULT_BDR with the overrides below
    localparam int P_NOM   = BIT_CLK * 10;
    localparam int P_SLOW  = 656;  // +2.5 %, tenths of a clk
    localparam int P_FAST  = 624;  // -2.5 %

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rxd;
    logic [7:0] data;
    logic       data_valid, frame_err, busy;

    always #5 clk = ~clk;

    uart_receiver #(
        .DEFAULT_BDR  (3_125_000),
        .SYS_CLK_DIV2 (100_000_000),
        .STOP_BIT     (2),
        .OVS          (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rxd        (rxd),
        .data       (data),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    typedef struct {
        bit         err;
        logic [7:0] val;
    } ev_t;

    ev_t        exp_q[$];
    ev_t        ev;
    logic [7:0] model_data;
    int         n_checks = 0;
    int         n_fail   = 0;
    int         n_valid  = 0;
    int         n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Per-clk comparison against the model: reset values, strobe content/order, data hold.
    always @(negedge clk) begin
        if (!rst_n) begin
            model_data = 8'h00;
            check("reset_data", 32'(data), 32'h0);
            check("reset_valid", 32'(data_valid), 32'h0);
            check("reset_ferr", 32'(frame_err), 32'h0);
            check("reset_busy", 32'(busy), 32'h0);
        end else begin
            check("strobe_exclusive", 32'(data_valid & frame_err), 32'h0);
            if (data_valid || frame_err) begin
                n_valid += int'(data_valid);
                n_err   += int'(frame_err);
                check("strobe_expected", 32'(exp_q.size() != 0), 32'h1);
                if (exp_q.size() != 0) begin
                    ev = exp_q.pop_front();
                    check("strobe_kind_ferr", 32'(frame_err), 32'(ev.err));
                    check("strobe_data", 32'(data), 32'(ev.val));
                    model_data = ev.val;
                end
            end else begin
                check("data_hold", 32'(data), 32'(model_data));
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Line bits are driven LSB first; bit i ends at round((i+1)*p10/10) clk.
    task automatic drive_line(input logic [10:0] bits, input int nbits, input int p10);
        int t_prev;
        int t_next;
        t_prev = 0;
        for (int i = 0; i < nbits; i++) begin
            t_next = ((i + 1) * p10 + 5) / 10;
            rxd = bits[i];
            wait_clk(t_next - t_prev);
            t_prev = t_next;
        end
    endtask

    function automatic logic [10:0] frame_of(input logic [7:0] b);
        return {2'b11, b, 1'b0};
    endfunction

    task automatic send_byte(input logic [7:0] b, input int p10);
        ev_t e;
        e.err = 1'b0;
        e.val = b;
        exp_q.push_back(e);
        drive_line(frame_of(b), 11, p10);
    endtask

    int v0, e0;
    logic [7:0] rb;

    initial begin
        rst_n = 1'b0;
        rxd   = 1'b1;
        wait_clk(5);
        rst_n = 1'b1;
        wait_clk(5);

        // 1: single clean frame
        v0 = n_valid;
        send_byte(8'hA5, P_NOM);
        wait_clk(8);
        check("t1_data", 32'(data), 32'hA5);
        check("t1_valid_count", 32'(n_valid - v0), 32'd1);
        check("t1_err_count", 32'(n_err), 32'd0);
        check("t1_busy_after", 32'(busy), 32'h0);
        check("t1_pending", 32'(exp_q.size()), 32'd0);

        // 2: glitch shorter than half a bit
        v0 = n_valid;
        rxd = 1'b0;
        wait_clk(20);
        rxd = 1'b1;
        check("t2_busy_during", 32'(busy), 32'h1);
        wait_clk(BIT_CLK + 16);
        check("t2_busy_after", 32'(busy), 32'h0);
        check("t2_valid_count", 32'(n_valid - v0), 32'd0);
        check("t2_err_count", 32'(n_err), 32'd0);

        // 3: first stop bit low, line held low for 5 more bit times
        v0 = n_valid;
        e0 = n_err;
        ev.err = 1'b1;
        ev.val = 8'h3C;
        exp_q.push_back(ev);
        drive_line(frame_of(8'h3C), 9, P_NOM);
        rxd = 1'b0;
        wait_clk(6 * BIT_CLK - 40);
        check("t3_busy_held", 32'(busy), 32'h1);
        check("t3_data", 32'(data), 32'h3C);
        wait_clk(40);
        check("t3_busy_line_low", 32'(busy), 32'h1);
        rxd = 1'b1;
        wait_clk(8);
        check("t3_busy_after", 32'(busy), 32'h0);
        check("t3_err_count", 32'(n_err - e0), 32'd1);
        check("t3_valid_count", 32'(n_valid - v0), 32'd0);
        wait_clk(BIT_CLK);

        // 4: back-to-back frames with no idle gap
        v0 = n_valid;
        e0 = n_err;
        send_byte(8'h00, P_NOM);
        send_byte(8'hFF, P_NOM);
        send_byte(8'h55, P_NOM);
        wait_clk(8);
        check("t4_valid_count", 32'(n_valid - v0), 32'd3);
        check("t4_err_count", 32'(n_err - e0), 32'd0);
        check("t4_data_last", 32'(data), 32'h55);
        check("t4_pending", 32'(exp_q.size()), 32'd0);

        // 5: reset in the middle of data bit 4; the rest of that frame is all ones
        v0 = n_valid;
        e0 = n_err;
        drive_line(frame_of(8'hF0), 5, P_NOM);
        rxd = 1'b1;
        wait_clk(BIT_CLK / 2);
        check("t5_busy_pre_reset", 32'(busy), 32'h1);
        rst_n = 1'b0;
        wait_clk(10);
        rst_n = 1'b1;
        wait_clk(1);
        check("t5_busy_released", 32'(busy), 32'h0);
        wait_clk(BIT_CLK / 2 - 11 + 5 * BIT_CLK);
        check("t5_no_strobe", 32'(n_valid - v0 + n_err - e0), 32'd0);
        send_byte(8'h81, P_NOM);
        wait_clk(8);
        check("t5_data", 32'(data), 32'h81);
        check("t5_valid_count", 32'(n_valid - v0), 32'd1);

        // 6: random bytes at +/-2.5 % bit period with random idle gaps (including none)
        for (int r = 0; r < 2; r++) begin
            v0 = n_valid;
            e0 = n_err;
            for (int k = 0; k < 40; k++) begin
                rb = 8'($urandom_range(255, 0));
                if ($urandom_range(3, 0) != 0) wait_clk(int'($urandom_range(20, 0)));
                send_byte(rb, (r == 0) ? P_SLOW : P_FAST);
            end
            wait_clk(8);
            check("t6_valid_count", 32'(n_valid - v0), 32'd40);
            check("t6_err_count", 32'(n_err - e0), 32'd0);
            check("t6_pending", 32'(exp_q.size()), 32'd0);
            check("t6_busy_after", 32'(busy), 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
